// File: rtl/mimo_input_loader_if.sv
// Stream-side bundle of the MIMO input loader: word handshake in, committed
// H/Y buses and status pulses out. WL falls back to 16 when parameters.v
// has not defined it.
`ifndef WL
`define WL 16
`endif

interface mimo_input_loader_if;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [`WL-1:0]    in_data;
    logic                     in_sof;
    logic [64*`WL-1:0]        Hmatrix_o;
    logic [8*`WL-1:0]         Yarray_o;
    logic                     frame_valid;
    logic                     err_sof;

    modport master (
        output in_valid, in_data, in_sof,
        input  in_ready, Hmatrix_o, Yarray_o, frame_valid, err_sof
    );

    modport slave (
        input  in_valid, in_data, in_sof,
        output in_ready, Hmatrix_o, Yarray_o, frame_valid, err_sof
    );
endinterface

// File: rtl/mimo_input_loader.sv
// Frame assembler in front of the 4x4 MIMO detector: collects 64 H words and
// 8 Y words into shadow registers, then commits them to the wide output
// buses in a single cycle and pulses frame_valid.
// Optional feature macro: MIMO_LOADER_SOF_EN (in_sof marks word 0 and aborts
// a frame in progress, reported by err_sof).
`ifndef WL
`define WL 16
`endif

module mimo_input_loader (
    input  logic                 clk,
    input  logic                 rst,
    mimo_input_loader_if.slave   bus
);
    localparam int WL = `WL;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD_H = 2'd1;
    localparam logic [1:0] LOAD_Y = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [6:0]        idx_q, idx_d;
    logic [64*WL-1:0]  shadow_h_q, shadow_h_d;
    logic [7*WL-1:0]   shadow_y_q, shadow_y_d;
    logic [64*WL-1:0]  hmatrix_q, hmatrix_d;
    logic [8*WL-1:0]   yarray_q, yarray_d;
    logic              frame_valid_q, frame_valid_d;
    logic              err_sof_q, err_sof_d;

    logic accept;
    logic restart;
    logic drop;
    logic abort;

    // Double buffering means the loader never needs to push back; it is
    // only unready while held in reset.
    assign bus.in_ready = rst;
    assign accept       = bus.in_valid & bus.in_ready;

`ifdef MIMO_LOADER_SOF_EN
    assign restart = accept & bus.in_sof;
    assign drop    = accept & ~bus.in_sof & (state_q == IDLE);
    assign abort   = restart & (state_q != IDLE);
`else
    logic unused_sof;
    assign unused_sof = bus.in_sof;
    assign restart    = accept & (state_q == IDLE);
    assign drop       = 1'b0;
    assign abort      = 1'b0;
`endif

    // Next-state logic: place each accepted word by idx, commit on idx 71.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        shadow_h_d    = shadow_h_q;
        shadow_y_d    = shadow_y_q;
        hmatrix_d     = hmatrix_q;
        yarray_d      = yarray_q;
        frame_valid_d = 1'b0;
        err_sof_d     = abort;

        if (restart) begin
            shadow_h_d[0 +: WL] = bus.in_data;
            idx_d               = 7'd1;
            state_d             = LOAD_H;
        end else if (accept && !drop) begin
            if (idx_q < 7'd64) begin
                shadow_h_d[idx_q[5:0]*WL +: WL] = bus.in_data;
                idx_d = idx_q + 7'd1;
                if (idx_q == 7'd63) begin
                    state_d = LOAD_Y;
                end
            end else if (idx_q < 7'd71) begin
                shadow_y_d[idx_q[2:0]*WL +: WL] = bus.in_data;
                idx_d = idx_q + 7'd1;
            end else begin
                hmatrix_d     = shadow_h_q;
                yarray_d      = {bus.in_data, shadow_y_q};
                frame_valid_d = 1'b1;
                idx_d         = 7'd0;
                state_d       = IDLE;
            end
        end
    end

    // State and data registers, all cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            idx_q         <= 7'd0;
            shadow_h_q    <= '0;
            shadow_y_q    <= '0;
            hmatrix_q     <= '0;
            yarray_q      <= '0;
            frame_valid_q <= 1'b0;
            err_sof_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            shadow_h_q    <= shadow_h_d;
            shadow_y_q    <= shadow_y_d;
            hmatrix_q     <= hmatrix_d;
            yarray_q      <= yarray_d;
            frame_valid_q <= frame_valid_d;
            err_sof_q     <= err_sof_d;
        end
    end

    assign bus.Hmatrix_o   = hmatrix_q;
    assign bus.Yarray_o    = yarray_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.err_sof     = err_sof_q;
endmodule

// File: tb/tb_mimo_input_loader.sv
// Self-checking bench for mimo_input_loader: table of whole-frame scenarios
// plus hand sequences for back-to-back frames, mid-frame reset and in_sof.
`ifndef WL
`define WL 16
`endif

module tb_mimo_input_loader;
    localparam int WL = `WL;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mimo_input_loader_if bus ();

    mimo_input_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string name;
        int    base;
        int    gap_after_a;
        int    gap_len_a;
        int    gap_after_b;
        int    gap_len_b;
        int    exp_cycles;
    } vector_t;

    vector_t vectors [0:3];

    int n_checks = 0;
    int n_fail   = 0;
    int cycle_cnt = 0;
    int fv_count, es_count, es_cycle, ready_bad;
    int fv_cycle [0:3];
    logic [64*WL-1:0] snap_h [0:3];
    logic [8*WL-1:0]  snap_y [0:3];

    // Single comparison with a FAIL line on mismatch.
    task automatic checkOutput(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One clock cycle of input, then sample and log the status outputs.
    task automatic applyStimulus(input logic v, input int d, input logic s);
        bus.in_valid = v;
        bus.in_data  = WL'(d);
        bus.in_sof   = s;
        @(posedge clk);
        #1;
        cycle_cnt++;
        if (bus.in_ready !== 1'b1) ready_bad++;
        if (bus.frame_valid === 1'b1) begin
            if (fv_count < 4) begin
                snap_h[fv_count]   = bus.Hmatrix_o;
                snap_y[fv_count]   = bus.Yarray_o;
                fv_cycle[fv_count] = cycle_cnt;
            end
            fv_count++;
        end
        if (bus.err_sof === 1'b1) begin
            es_count++;
            es_cycle = cycle_cnt;
        end
    endtask

    task automatic clearCounts();
        fv_count  = 0;
        es_count  = 0;
        es_cycle  = -1;
        ready_bad = 0;
    endtask

    task automatic applyReset();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_sof   = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        clearCounts();
    endtask

    // 72 words base..base+71 with optional idle gaps after two word indices.
    task automatic sendFrame(input int base, input int ga, input int gla,
                             input int gb, input int glb, input logic sof_first,
                             output int start);
        start = cycle_cnt + 1;
        for (int k = 0; k < 72; k++) begin
            applyStimulus(1'b1, base + k, (k == 0) ? sof_first : 1'b0);
            if (k == ga) repeat (gla) applyStimulus(1'b0, 0, 1'b0);
            if (k == gb) repeat (glb) applyStimulus(1'b0, 0, 1'b0);
        end
        bus.in_valid = 1'b0;
    endtask

    // Compare a captured commit against the expected base-relative contents.
    task automatic checkFrame(input string tag, input int p, input int base);
        for (int k = 0; k < 64; k++)
            checkOutput($sformatf("%s_H%0d", tag, k), longint'(snap_h[p][k*WL +: WL]), base + k);
        for (int j = 0; j < 8; j++)
            checkOutput($sformatf("%s_Y%0d", tag, j), longint'(snap_y[p][j*WL +: WL]), base + 64 + j);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int start;
        int s0;

        vectors[0] = '{"plain",   1,   -1, 0, -1, 0, 72};
        vectors[1] = '{"gaps",    1,   30, 5, 68, 3, 80};
        vectors[2] = '{"plain2",  201, -1, 0, -1, 0, 72};
        vectors[3] = '{"edgegap", 1000, 0, 1, 70, 2, 75};

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_sof   = 1'b0;
        rst = 1'b0;
        clearCounts();
        @(posedge clk);
        #1;
        checkOutput("rst_in_ready",    bus.in_ready, 0);
        checkOutput("rst_frame_valid", bus.frame_valid, 0);
        checkOutput("rst_err_sof",     bus.err_sof, 0);
        checkOutput("rst_H_zero",      longint'(bus.Hmatrix_o == '0), 1);
        checkOutput("rst_Y_zero",      longint'(bus.Yarray_o == '0), 1);

        for (int v = 0; v < 4; v++) begin
            applyReset();
            applyStimulus(1'b0, 0, 1'b0);
            sendFrame(vectors[v].base, vectors[v].gap_after_a, vectors[v].gap_len_a,
                      vectors[v].gap_after_b, vectors[v].gap_len_b, 1'b1, start);
            repeat (3) applyStimulus(1'b0, 0, 1'b0);
            checkOutput({vectors[v].name, "_pulses"}, fv_count, 1);
            checkOutput({vectors[v].name, "_latency"}, fv_cycle[0] - start + 1, vectors[v].exp_cycles);
            checkFrame(vectors[v].name, 0, vectors[v].base);
            checkOutput({vectors[v].name, "_hold_H0"}, longint'(bus.Hmatrix_o[0 +: WL]), vectors[v].base);
            checkOutput({vectors[v].name, "_hold_Y7"}, longint'(bus.Yarray_o[7*WL +: WL]), vectors[v].base + 71);
            checkOutput({vectors[v].name, "_err_sof"}, es_count, 0);
            checkOutput({vectors[v].name, "_ready"}, ready_bad, 0);
        end

        // Back-to-back frames with no idle cycle between them.
        applyReset();
        sendFrame(1, -1, 0, -1, 0, 1'b1, start);
        sendFrame(101, -1, 0, -1, 0, 1'b1, start);
        applyStimulus(1'b0, 0, 1'b0);
        checkOutput("b2b_pulses", fv_count, 2);
        checkOutput("b2b_spacing", fv_cycle[1] - fv_cycle[0], 72);
        checkFrame("b2b_f1", 0, 1);
        checkFrame("b2b_f2", 1, 101);

        // Reset in the middle of a frame wipes committed outputs too.
        clearCounts();
        for (int k = 0; k < 50; k++) applyStimulus(1'b1, 301 + k, k == 0);
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midrst_H_zero", longint'(bus.Hmatrix_o == '0), 1);
        checkOutput("midrst_Y_zero", longint'(bus.Yarray_o == '0), 1);
        checkOutput("midrst_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) applyStimulus(1'b0, 0, 1'b0);
        checkOutput("midrst_no_pulse", fv_count, 0);
        checkOutput("midrst_still_zero", longint'(bus.Hmatrix_o == '0), 1);
        sendFrame(201, -1, 0, -1, 0, 1'b1, start);
        applyStimulus(1'b0, 0, 1'b0);
        checkOutput("midrst_pulses", fv_count, 1);
        checkFrame("midrst", 0, 201);

`ifdef MIMO_LOADER_SOF_EN
        // Words without in_sof in IDLE are dropped.
        applyReset();
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 7 + k, 1'b0);
        sendFrame(1, -1, 0, -1, 0, 1'b1, start);
        applyStimulus(1'b0, 0, 1'b0);
        checkOutput("drop_pulses", fv_count, 1);
        checkOutput("drop_latency", fv_cycle[0] - start + 1, 72);
        checkFrame("drop", 0, 1);

        // A new in_sof after 40 words aborts the partial frame.
        clearCounts();
        s0 = cycle_cnt + 1;
        for (int k = 0; k < 40; k++) applyStimulus(1'b1, 500 + k, k == 0);
        sendFrame(601, -1, 0, -1, 0, 1'b1, start);
        applyStimulus(1'b0, 0, 1'b0);
        checkOutput("abort40_err_count", es_count, 1);
        checkOutput("abort40_err_at", es_cycle - s0, 40);
        checkOutput("abort40_pulses", fv_count, 1);
        checkFrame("abort40", 0, 601);

        // in_sof on the would-be final word aborts instead of committing.
        clearCounts();
        s0 = cycle_cnt + 1;
        for (int k = 0; k < 71; k++) applyStimulus(1'b1, 700 + k, k == 0);
        sendFrame(800, -1, 0, -1, 0, 1'b1, start);
        applyStimulus(1'b0, 0, 1'b0);
        checkOutput("abort71_err_count", es_count, 1);
        checkOutput("abort71_err_at", es_cycle - s0, 71);
        checkOutput("abort71_pulses", fv_count, 1);
        checkFrame("abort71", 0, 800);
`else
        // in_sof has no effect: first word without it still starts a frame,
        // and a stray in_sof mid-frame is ignored.
        applyReset();
        s0 = cycle_cnt + 1;
        for (int k = 0; k < 72; k++) applyStimulus(1'b1, 50 + k, k == 10);
        applyStimulus(1'b0, 0, 1'b0);
        checkOutput("nosof_pulses", fv_count, 1);
        checkOutput("nosof_latency", fv_cycle[0] - s0 + 1, 72);
        checkOutput("nosof_err_sof", es_count, 0);
        checkFrame("nosof", 0, 50);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
